// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the shift sequencer.
// Op codes, FSM states and the rotate second-pass amount helper.
package shift_seq_pkg;

  localparam int W   = 32;
  localparam int SAW = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Left amount that completes a rotate: (32 - sa) mod 32
  function automatic logic [SAW-1:0] ror_sa2(
    input logic [SAW-1:0] sa
  );
    return {SAW{1'b0}} - sa;
  endfunction

endpackage

// File: rtl/shift_sequencer_rr_arb2.sv
// Two-request round-robin arbiter, purely combinational.
// The last-grant register lives in the parent.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = 1'b0;
    unique case (1'b1)
      (req == 2'b11): grant_id = ~last_grant;
      (req == 2'b10): grant_id = 1'b1;
      (req == 2'b01): grant_id = 1'b0;
      (req == 2'b00): grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Shares one external 32-bit barrel shifter between two requesters.
// Optional pass counter: define SHIFT_SEQUENCER_PASS_CNT_EN.
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic           Clk,
  input  logic           Clrn,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_x,
  input  logic [SAW-1:0] req0_sa,
  input  logic [1:0]     req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_x,
  input  logic [SAW-1:0] req1_sa,
  input  logic [1:0]     req1_op,
  output logic [W-1:0]   sh_x,
  output logic [SAW-1:0] sh_sa,
  output logic           sh_arith,
  output logic           sh_right,
  input  logic [W-1:0]   sh_result,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [W-1:0]   resp_data,
  output logic [W-1:0]   pass_cnt
);

  state_e         state_q;
  logic           last_grant_q;
  logic           id_q;
  op_e            op_q;
  logic [W-1:0]   x_q;
  logic [SAW-1:0] sa_q;
  logic [W-1:0]   acc_q;

  logic grant_valid;
  logic grant_id;
  logic accept;

  rr_arb2 u_arb (
    .req         ({req1_valid, req0_valid}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign accept     = (state_q == IDLE) && grant_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_data  = acc_q;

  always_comb begin
    sh_x     = '0;
    sh_sa    = '0;
    sh_arith = 1'b0;
    sh_right = 1'b0;
    unique case (state_q)
      PASS1: begin
        sh_x     = x_q;
        sh_sa    = sa_q;
        sh_right = (op_q != OP_SLL);
        sh_arith = (op_q == OP_SRA);
      end
      PASS2: begin
        sh_x  = x_q;
        sh_sa = ror_sa2(sa_q);
      end
      IDLE, RESP: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= OP_SLL;
      x_q          <= '0;
      sa_q         <= '0;
      acc_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_valid) begin
            id_q         <= grant_id;
            last_grant_q <= grant_id;
            x_q          <= grant_id ? req1_x : req0_x;
            sa_q         <= grant_id ? req1_sa : req0_sa;
            op_q         <= op_e'(grant_id ? req1_op : req0_op);
            state_q      <= PASS1;
          end
        end
        PASS1: begin
          acc_q <= sh_result;
          // rotate by zero is already complete after one pass
          if (op_q == OP_ROR && sa_q != '0) begin
            state_q <= PASS2;
          end else begin
            state_q <= RESP;
          end
        end
        PASS2: begin
          acc_q   <= acc_q | sh_result;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef SHIFT_SEQUENCER_PASS_CNT_EN
  logic [W-1:0] pass_cnt_q;

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      pass_cnt_q <= '0;
    end else if (state_q == PASS1 || state_q == PASS2) begin
      pass_cnt_q <= pass_cnt_q + 1'b1;
    end
  end

  assign pass_cnt = pass_cnt_q;
`else
  assign pass_cnt = '0;
`endif

endmodule
